// File: rtl/wgt_buf_pp.sv
// rtl/wgt_buf_pp.sv - ping-pong weight buffer: shadow bank fills serially, swap copies it to the active bank
module wgt_buf_pp #(
  parameter int DATA_W = 8,
  parameter int NTAP   = 9,
  parameter int CNT_W  = $clog2(NTAP)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      wgt_in,
  input  logic                   wgt_in_valid,
  output logic                   wgt_in_ready,
  input  logic                   swap_req,
  output logic                   swap_ack,
  input  logic                   flush,
  output logic                   shadow_full,
  output logic [CNT_W-1:0]       load_cnt,
  output logic [NTAP*DATA_W-1:0] wgt_out,
  output logic                   wgt_valid
);

  localparam int                 BANK_W   = NTAP * DATA_W;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NTAP - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_FULL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;
  logic [BANK_W-1:0]   shadow_q, shadow_d;
  logic [BANK_W-1:0]   active_q, active_d;
  logic                wgt_valid_q, wgt_valid_d;
  logic                shadow_full_q, shadow_full_d;
  logic                swap_ack_q, swap_ack_d;

  // Ready depends only on the registered state so the upstream reader never sees a loop through valid.
  assign wgt_in_ready = (state_q == S_LOAD);
  assign swap_ack     = swap_ack_q;
  assign shadow_full  = shadow_full_q;
  assign load_cnt     = load_cnt_q;
  assign wgt_out      = active_q;
  assign wgt_valid    = wgt_valid_q;

  // Next-state: flush overrides everything; LOAD shifts accepted words in, FULL waits for a swap.
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    wgt_valid_d   = wgt_valid_q;
    shadow_full_d = shadow_full_q;
    swap_ack_d    = 1'b0;

    if (flush) begin
      state_d       = S_LOAD;
      load_cnt_d    = '0;
      shadow_d      = '0;
      active_d      = '0;
      wgt_valid_d   = 1'b0;
      shadow_full_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (wgt_in_valid) begin
            // New word enters tap 0; the oldest word of the kernel drifts towards tap NTAP-1.
            shadow_d = {shadow_q[BANK_W-DATA_W-1:0], wgt_in};
            if (load_cnt_q == CNT_LAST) begin
              load_cnt_d    = '0;
              state_d       = S_FULL;
              shadow_full_d = 1'b1;
            end else begin
              load_cnt_d = load_cnt_q + CNT_W'(1);
            end
          end
        end
        S_FULL: begin
          // Shadow is left intact after the copy; the next fill simply shifts over it.
          if (swap_req) begin
            active_d      = shadow_q;
            wgt_valid_d   = 1'b1;
            state_d       = S_LOAD;
            shadow_full_d = 1'b0;
            swap_ack_d    = 1'b1;
          end
        end
        default: begin
          state_d = S_LOAD;
        end
      endcase
    end
  end

  // State and bank registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_LOAD;
      load_cnt_q    <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      wgt_valid_q   <= 1'b0;
      shadow_full_q <= 1'b0;
      swap_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      wgt_valid_q   <= wgt_valid_d;
      shadow_full_q <= shadow_full_d;
      swap_ack_q    <= swap_ack_d;
    end
  end

endmodule
